cmos_capture: RTL and testbench

- Receiving end of the camera-style video stream (cmos_vsync / cmos_href plus 24-bit pixel data).
- Tracks frame and line timing, assigns each active pixel its BMP byte address (row-major, 3 bytes per pixel, after a 54-byte header), and emits registered write strobes into the image buffer.
- Measures each received frame's width and height and flags geometry errors, so benches and downstream filters can confirm the source matches the configured resolution.

---
 rtl/cmos_capture.sv | 133 +++++++++++++
 tb/tb_cmos_capture.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cmos_capture.sv
// cmos_capture: camera stream receiver; turns vsync/href/data into BMP-addressed pixel writes and measures each frame's geometry.
module cmos_capture #(
  parameter logic [15:0] H_ACTIVE  = 16'd800,
  parameter logic [15:0] V_ACTIVE  = 16'd480,
  parameter logic        VS_POL    = 1'b0,
  parameter int          BPP       = 3,
  parameter int          HDR_BYTES = 54
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [23:0] cmos_data,
  output logic        pix_we,
  output logic [31:0] pix_addr,
  output logic [23:0] pix_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic [10:0] frame_width,
  output logic [10:0] frame_height,
  output logic        size_err,
  output logic [15:0] frame_cnt
);
  typedef enum logic [1:0] {WAIT_SYNC, SYNC, FRAME} state_t;
  localparam logic [31:0] LINE_BYTES = 32'(H_ACTIVE) * 32'(BPP);
  state_t      state_q, state_d;
  logic        href_q, sync_q, line_err_q, line_err_d;
  logic [10:0] x_q, x_d, y_q, y_d, last_len_q, last_len_d;
  logic        pix_we_q, pix_we_d, frame_start_q, frame_start_d, frame_done_q, frame_done_d;
  logic        size_err_q, size_err_d;
  logic [31:0] pix_addr_q, pix_addr_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, width_q, width_d, height_q, height_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sync, sync_rise, sync_fall, in_frame, line_end, pixel, in_range;
  assign sync = cmos_vsync == VS_POL;
  always_comb begin
    sync_rise = sync & ~sync_q;
    sync_fall = ~sync & sync_q;
    in_frame  = state_q == FRAME;
    // a sync arriving mid-line closes that line before closing the frame
    line_end  = in_frame & ((href_q & ~cmos_href) | (sync_rise & cmos_href));
    pixel     = in_frame & cmos_href & ~sync_rise;
    in_range  = ({5'd0, x_q} < H_ACTIVE) && ({5'd0, y_q} < V_ACTIVE);
    state_d    = state_q;
    x_d        = pixel ? ((x_q == 11'h7ff) ? x_q : x_q + 11'd1) : x_q;
    y_d        = y_q;
    last_len_d = last_len_q;
    line_err_d = line_err_q;
    if (line_end) begin
      x_d        = 11'd0;
      y_d        = (y_q == 11'h7ff) ? y_q : y_q + 11'd1;
      last_len_d = x_q;
      line_err_d = line_err_q | ({5'd0, x_q} != H_ACTIVE);
    end
    pix_we_d      = pixel & in_range;
    pix_data_d    = pixel ? cmos_data : pix_data_q;
    pix_x_d       = pixel ? x_q : pix_x_q;
    pix_y_d       = pixel ? y_q : pix_y_q;
    pix_addr_d    = pixel ? 32'(y_q) * LINE_BYTES + 32'(x_q) * 32'(BPP) + 32'(HDR_BYTES) : pix_addr_q;
    frame_start_d = (state_q == SYNC) & sync_fall;
    frame_done_d  = in_frame & sync_rise;
    width_d       = frame_done_d ? last_len_d : width_q;
    height_d      = frame_done_d ? y_d : height_q;
    size_err_d    = frame_done_d ? (line_err_d | ({5'd0, y_d} != V_ACTIVE)) : size_err_q;
    frame_cnt_d   = frame_cnt_q + 16'(frame_done_d);
    case (state_q)
      WAIT_SYNC: state_d = sync ? SYNC : WAIT_SYNC;
      SYNC: begin
        x_d        = 11'd0;
        y_d        = 11'd0;
        line_err_d = 1'b0;
        state_d    = sync_fall ? FRAME : SYNC;
      end
      FRAME:   state_d = sync_rise ? SYNC : FRAME;
      default: state_d = WAIT_SYNC;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_SYNC;
      href_q        <= 1'b0;
      sync_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      last_len_q    <= '0;
      line_err_q    <= 1'b0;
      pix_we_q      <= 1'b0;
      pix_addr_q    <= '0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      size_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      href_q        <= cmos_href;
      sync_q        <= sync;
      x_q           <= x_d;
      y_q           <= y_d;
      last_len_q    <= last_len_d;
      line_err_q    <= line_err_d;
      pix_we_q      <= pix_we_d;
      pix_addr_q    <= pix_addr_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      width_q       <= width_d;
      height_q      <= height_d;
      size_err_q    <= size_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end
  assign pix_we       = pix_we_q;
  assign pix_addr     = pix_addr_q;
  assign pix_data     = pix_data_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign frame_start  = frame_start_q;
  assign frame_done   = frame_done_q;
  assign frame_width  = width_q;
  assign frame_height = height_q;
  assign size_err     = size_err_q;
  assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: scoreboard bench on a reduced 16x8 geometry; stimulus pushes expected writes and frame reports, a negedge monitor pops and compares.
module tb_cmos_capture;
  localparam int H = 16, V = 8;
  logic clk = 0, rst_n = 0, vs = 1, href = 0;
  logic [23:0] d = '0;
  logic pix_we, frame_start, frame_done, size_err;
  logic [31:0] pix_addr;
  logic [23:0] pix_data;
  logic [10:0] pix_x, pix_y, frame_width, frame_height;
  logic [15:0] frame_cnt;
  cmos_capture #(.H_ACTIVE(16'(H)), .V_ACTIVE(16'(V))) dut (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(vs), .cmos_href(href), .cmos_data(d),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_done(frame_done), .frame_width(frame_width),
    .frame_height(frame_height), .size_err(size_err), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] a; logic [23:0] d; logic [10:0] x, y;} wr_t;
  typedef struct packed {logic [10:0] w, h; logic e; logic [15:0] c;} fr_t;
  wr_t wq[$];
  fr_t fq[$];
  wr_t we_exp;
  fr_t fr_exp;
  int pass_n = 0, tot_n = 0, fs_seen = 0, fs_exp = 0;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  always @(negedge clk) begin
    if (frame_start) fs_seen++;
    if (pix_we) begin
      if (wq.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_write: x=%0d y=%0d addr=%0d, expected no write", pix_x, pix_y, pix_addr);
      end else begin
        we_exp = wq.pop_front();
        chk("pix_addr", pix_addr, we_exp.a);
        chk("pix_data", pix_data, we_exp.d);
        chk("pix_x", pix_x, we_exp.x);
        chk("pix_y", pix_y, we_exp.y);
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_frame_done: cnt=%0d, expected none", frame_cnt);
      end else begin
        fr_exp = fq.pop_front();
        chk("frame_width", frame_width, fr_exp.w);
        chk("frame_height", frame_height, fr_exp.h);
        chk("size_err", size_err, fr_exp.e);
        chk("frame_cnt", frame_cnt, fr_exp.c);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input int x, input int y, input bit en);
    href = 1;
    d = {8'(y), 8'(x), 8'h5A};
    if (en && x < H && y < V)
      wq.push_back('{a: 32'(y * H * 3 + x * 3 + 54), d: d, x: 11'(x), y: 11'(y)});
    tick;
  endtask
  task automatic line(input int y, input int n, input bit en);
    for (int x = 0; x < n; x++) pix(x, y, en);
    href = 0;
    repeat (3) tick;
  endtask
  task automatic sync_pulse(input bit ends, input fr_t e);
    vs = 0;
    if (ends) fq.push_back(e);
    repeat (3) tick;
    vs = 1;
    fs_exp++;
    repeat (2) tick;
  endtask
  task automatic reset_checks;
    chk("rst_pix_we", pix_we, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_xy", {pix_x, pix_y}, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_geometry", {frame_width, frame_height, size_err}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
  endtask
  initial begin
    repeat (2) tick;
    reset_checks();
    rst_n = 1;
    tick;
    line(0, H, 0);
    sync_pulse(0, '0);
    for (int y = 0; y < V; y++) line(y, H, 1);
    sync_pulse(1, '{w: 11'd16, h: 11'd8, e: 1'b1 & 1'b0, c: 16'd1});
    for (int y = 0; y < V; y++) line(y, (y == 3) ? H - 1 : H, 1);
    sync_pulse(1, '{w: 11'd16, h: 11'd8, e: 1'b1, c: 16'd2});
    for (int y = 0; y < V + 1; y++) line(y, (y == 2) ? H + 2 : H, 1);
    sync_pulse(1, '{w: 11'd16, h: 11'd9, e: 1'b1, c: 16'd3});
    for (int y = 0; y < V - 1; y++) line(y, H, 1);
    for (int x = 0; x < 5; x++) pix(x, V - 1, 1);
    vs = 0;
    d = 24'hFFFFFF;
    fq.push_back('{w: 11'd5, h: 11'd8, e: 1'b1, c: 16'd4});
    tick;
    href = 0;
    repeat (2) tick;
    vs = 1;
    fs_exp++;
    repeat (2) tick;
    for (int y = 0; y < 3; y++) line(y, H, 1);
    rst_n = 0;
    tick;
    reset_checks();
    rst_n = 1;
    tick;
    for (int y = 3; y < 5; y++) line(y, H, 0);
    sync_pulse(0, '0);
    for (int y = 0; y < V; y++) line(y, H, 1);
    sync_pulse(1, '{w: 11'd16, h: 11'd8, e: 1'b0, c: 16'd1});
    repeat (5) tick;
    chk("writes_outstanding", wq.size(), 0);
    chk("frames_outstanding", fq.size(), 0);
    chk("frame_start_count", fs_seen, fs_exp);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
